mmio_uart_tx: RTL and testbench

- Memory-mapped console transmitter that sits directly downstream of the core's data-memory stage.
- Snoops the same store bus the data memory sees (MemWrite, address, store data).
- Bytes stored to TX_ADDR are queued in a FIFO and serialized as 8N1 UART frames.
- A status word at STATUS_ADDR is returned to the core's load path so software can poll before writing.

---
 rtl/mmio_uart_tx_if.sv | 21 ++
 rtl/mmio_uart_tx.sv | 154 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Store/load bus shared by the data-memory stage and the console transmitter.
// The core drives MemWrite/MemRead/memAddr/writeData_M. The transmitter returns
// hit (status-register select) and readData_S (status word) to the load path.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic        MemRead;
  logic [63:0] memAddr;
  logic [63:0] writeData_M;
  logic        hit;
  logic [63:0] readData_S;

  modport master (
    output MemWrite, MemRead, memAddr, writeData_M,
    input  hit, readData_S
  );

  modport slave (
    input  MemWrite, MemRead, memAddr, writeData_M,
    output hit, readData_S
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter.
// Snoops the core store bus. Bytes stored to TX_ADDR enter a FIFO and are sent
// on tx LSB first, CLKS_PER_BIT clocks per bit. A load from STATUS_ADDR raises
// hit and returns {60'b0, overflow, busy, empty, full} on readData_S. A store to
// STATUS_ADDR clears the sticky overflow flag.
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of the store/load bus (mmio_uart_tx_if)
//   tx   - serial output, idles high
module mmio_uart_tx #(
  parameter logic [63:0] TX_ADDR      = 64'h800,
  parameter logic [63:0] STATUS_ADDR  = 64'h808,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  mmio_uart_tx_if.slave bus,
  output logic         tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BC_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;

  logic fifo_full, fifo_empty;
  logic push_req, push_ok, pop, ovf_clr, bit_end;
  logic unused_wdata_hi;

  assign unused_wdata_hi = ^bus.writeData_M[63:8];

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push_req   = bus.MemWrite && (bus.memAddr == TX_ADDR);
  assign ovf_clr    = bus.MemWrite && (bus.memAddr == STATUS_ADDR);
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign bit_end    = (bit_cnt_q == BIT_LAST);

  assign bus.hit        = bus.MemRead && (bus.memAddr == STATUS_ADDR);
  assign bus.readData_S = {60'd0, overflow_q, (state_q != S_IDLE), fifo_empty, fifo_full};

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= bus.writeData_M[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (push_req && !push_ok) overflow_q <= 1'b1;
      else if (ovf_clr)         overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_mem[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from registered state so reset forces the line high without a clock.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int FRAME_GAP = 10 * C + 1;

  logic clk;
  logic rst;
  logic tx;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .TX_ADDR     (64'h800),
    .STATUS_ADDR (64'h808),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Line receiver: samples mid-bit on falling clock edges.
  logic [7:0] rx_byte[$];
  longint     rx_cyc[$];
  int         rx_starts = 0;
  int         frame_err = 0;
  longint     ncyc = 0;

  initial begin
    int cnt;
    bit act;
    logic [7:0] sh;
    longint st;
    act = 0; cnt = 0; sh = '0; st = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        act = 0;
      end else if (!act) begin
        if (tx == 1'b0) begin
          act = 1; cnt = 0; st = ncyc; rx_starts++;
        end
      end else begin
        cnt++;
        if (cnt >= C + C/2 && cnt < 9*C && ((cnt - C - C/2) % C) == 0)
          sh = {tx, sh[7:1]};
        if (cnt == 9*C + C/2) begin
          if (tx !== 1'b1) frame_err++;
          rx_byte.push_back(sh);
          rx_cyc.push_back(st);
          act = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic store(input logic [63:0] a, input logic [7:0] d);
    bus.MemWrite    = 1'b1;
    bus.memAddr     = a;
    bus.writeData_M = {56'hFFFF_FFFF_FFFF_FF, d};
    @(negedge clk);
    bus.MemWrite    = 1'b0;
    bus.memAddr     = '0;
  endtask

  task automatic status_is(input string name, input logic [63:0] exp);
    bus.MemRead = 1'b1;
    bus.memAddr = 64'h808;
    #1;
    chk({name, " hit"}, {63'd0, bus.hit}, 64'd1);
    chk(name, bus.readData_S, exp);
    bus.MemRead = 1'b0;
    bus.memAddr = '0;
  endtask

  task automatic wait_frames(input string name, input int target);
    int i;
    for (i = 0; i < 12 * FRAME_GAP && rx_byte.size() < target; i++) @(negedge clk);
    chk({name, " frames arrived"}, {63'd0, rx_byte.size() >= target}, 64'd1);
  endtask

  task automatic check_seq(input string name, input int base, input int n, input logic [7:0] first);
    for (int i = 0; i < n && base + i < rx_byte.size(); i++) begin
      chk({name, " byte"}, {56'd0, rx_byte[base+i]}, {56'd0, first + 8'(i)});
      if (i > 0)
        chk({name, " spacing"}, 64'(rx_cyc[base+i] - rx_cyc[base+i-1]), 64'(FRAME_GAP));
    end
  endtask

  typedef struct {
    logic        mw;
    logic        mr;
    logic [63:0] addr;
    logic [7:0]  data;
    logic        exp_hit;
    logic [63:0] exp_st;
  } vec_t;

  vec_t vt[11];

  initial begin
    int base;
    int s0;
    bit found;
    logic [7:0] lb;
    logic e;

    vt[0]  = '{1'b0, 1'b1, 64'h808,           8'h00, 1'b1, 64'h2};
    vt[1]  = '{1'b0, 1'b1, 64'h800,           8'h00, 1'b0, 64'h2};
    vt[2]  = '{1'b0, 1'b1, 64'h809,           8'h00, 1'b0, 64'h2};
    vt[3]  = '{1'b0, 1'b0, 64'h808,           8'h00, 1'b0, 64'h2};
    vt[4]  = '{1'b0, 1'b1, 64'h1000_0808,     8'h00, 1'b0, 64'h2};
    vt[5]  = '{1'b1, 1'b0, 64'h801,           8'hFF, 1'b0, 64'h2};
    vt[6]  = '{1'b0, 1'b1, 64'h808,           8'h00, 1'b1, 64'h2};
    vt[7]  = '{1'b1, 1'b0, 64'h100_0000_0800, 8'h5A, 1'b0, 64'h2};
    vt[8]  = '{1'b0, 1'b1, 64'h808,           8'h00, 1'b1, 64'h2};
    vt[9]  = '{1'b1, 1'b1, 64'h808,           8'h33, 1'b1, 64'h2};
    vt[10] = '{1'b0, 1'b1, 64'h808,           8'h00, 1'b1, 64'h2};

    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
    bus.memAddr = '0; bus.writeData_M = '0;
    rst = 1'b1;

    // Reset
    repeat (3) @(negedge clk);
    chk("reset tx", {63'd0, tx}, 64'd1);
    status_is("reset status", 64'h2);
    rst = 1'b0;
    @(negedge clk);

    // Address decode / status table
    foreach (vt[i]) begin
      bus.MemWrite    = vt[i].mw;
      bus.MemRead     = vt[i].mr;
      bus.memAddr     = vt[i].addr;
      bus.writeData_M = {56'd0, vt[i].data};
      #1;
      chk($sformatf("vec%0d hit", i), {63'd0, bus.hit}, {63'd0, vt[i].exp_hit});
      chk($sformatf("vec%0d status", i), bus.readData_S, vt[i].exp_st);
      @(negedge clk);
    end
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0; bus.memAddr = '0;
    repeat (3) @(negedge clk);
    chk("no frame from other addrs", 64'(rx_starts), 64'd0);

    // Single byte, cycle by cycle
    lb = 8'hA5;
    store(64'h800, lb);
    for (int k = 0; k <= 41; k++) begin
      if (k == 0)       e = 1'b1;
      else if (k <= 4)  e = 1'b0;
      else if (k <= 36) e = lb[(k-5)/4];
      else              e = 1'b1;
      chk($sformatf("single tx k=%0d", k), {63'd0, tx}, {63'd0, e});
      if (k == 40) chk("single busy before end", {63'd0, bus.readData_S[2]}, 64'd1);
      if (k == 41) chk("single busy after end", {63'd0, bus.readData_S[2]}, 64'd0);
      if (k < 41) @(negedge clk);
    end
    wait_frames("single", 1);
    if (rx_byte.size() >= 1) chk("single rx byte", {56'd0, rx_byte[0]}, 64'hA5);

    // Burst of 9: fills exactly, no drop
    base = rx_byte.size();
    for (int i = 1; i <= 9; i++) store(64'h800, 8'(i));
    status_is("burst status", 64'h5);
    wait_frames("burst", base + 9);
    check_seq("burst", base, 9, 8'h01);
    repeat (5) @(negedge clk);
    status_is("burst drained", 64'h2);

    // Overflow: 10th byte dropped
    base = rx_byte.size();
    for (int i = 0; i < 10; i++) store(64'h800, 8'h11 + 8'(i));
    status_is("ovf status", 64'hD);
    wait_frames("ovf", base + 9);
    check_seq("ovf", base, 9, 8'h11);
    repeat (2 * FRAME_GAP) @(negedge clk);
    chk("ovf frame count", 64'(rx_byte.size() - base), 64'd9);
    status_is("ovf sticky", 64'hA);
    store(64'h808, 8'h00);
    status_is("ovf cleared", 64'h2);

    // Full FIFO with push on the pop edge
    base = rx_byte.size();
    for (int i = 0; i < 9; i++) store(64'h800, 8'h21 + 8'(i));
    status_is("full status", 64'h5);
    found = 0;
    for (int i = 0; i < 2 * FRAME_GAP && !found; i++) begin
      #1;
      if (bus.readData_S[2] == 1'b0) found = 1;
      else @(negedge clk);
    end
    chk("full idle seen", {63'd0, found}, 64'd1);
    chk("full at idle", {63'd0, bus.readData_S[0]}, 64'd1);
    store(64'h800, 8'h55);
    status_is("full push+pop", 64'h5);
    wait_frames("fullpop", base + 10);
    check_seq("fullpop", base, 9, 8'h21);
    if (rx_byte.size() >= base + 10) begin
      chk("fullpop last byte", {56'd0, rx_byte[base+9]}, 64'h55);
      chk("fullpop last spacing", 64'(rx_cyc[base+9] - rx_cyc[base+8]), 64'(FRAME_GAP));
    end
    repeat (5) @(negedge clk);
    status_is("fullpop drained", 64'h2);

    // Reset in the middle of data bit 3
    base = rx_byte.size();
    store(64'h800, 8'hC3);
    store(64'h800, 8'h3C);
    repeat (17) @(negedge clk);
    chk("mid tx bit3", {63'd0, tx}, 64'd0);
    #2 rst = 1'b1;
    #1 chk("mid reset tx async", {63'd0, tx}, 64'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    status_is("mid post-reset status", 64'h2);
    s0 = rx_starts;
    repeat (3 * FRAME_GAP) @(negedge clk);
    chk("mid no new frames", 64'(rx_starts - s0), 64'd0);
    chk("mid no partial byte", 64'(rx_byte.size() - base), 64'd0);
    chk("stop bits", 64'(frame_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
